// File: rtl/register_access_controller.sv
// ---------------------------------------------------------------------------
// register_access_controller
//
// Initiator-side sequencer for the 16x32 register file. Operand-fetch
// requests (rs1/rs2) arrive over a valid/ready handshake; the block issues
// both reads to the register file. It forwards any writeback that lands in
// the issue or fetch window, so returned operands are never stale. Both
// operands are then presented on a registered valid/ready output.
// Writebacks pass straight through to the register file write port in every
// state.
//
// Ports
//   clk, reset_n          core clock, asynchronous active-low reset
//   req_valid/req_ready   operand-fetch request handshake
//   req_rs1, req_rs2      source register addresses (4 bit)
//   op_valid/op_ready     operand result handshake
//   op_a, op_b            registered operands (32 bit)
//   wb_valid/addr/data    writeback request, always accepted
//   rf_available          register-file operation strobe (issue or writeback)
//   rf_write_en/addr/data register-file write port
//   rf_read_addr_a/b      register-file read addresses
//   rf_read_data_a/b      register-file read data, valid the cycle after issue
// ---------------------------------------------------------------------------
module register_access_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_rs1,
    input  logic [3:0]  req_rs2,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        wb_valid,
    input  logic [3:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        rf_available,
    output logic        rf_write_en,
    output logic [3:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    output logic [3:0]  rf_read_addr_a,
    input  logic [31:0] rf_read_data_a,
    output logic [3:0]  rf_read_addr_b,
    input  logic [31:0] rf_read_data_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        issue;

    logic [3:0]  rs1_q;
    logic [3:0]  rs2_q;

    logic        fwd_a_q;
    logic        fwd_b_q;
    logic [31:0] fwd_data_a_q;
    logic [31:0] fwd_data_b_q;

    logic        issue_hit_a;
    logic        issue_hit_b;
    logic        fetch_hit_a;
    logic        fetch_hit_b;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

    // An issue can never happen while reset is held, even though req_ready
    // reads 1 in the reset (IDLE) state.
    assign issue = req_valid & req_ready & reset_n;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. The VALID state accepts a new
    // request only in the cycle the current operands are consumed, which
    // gives back-to-back operation at one request per two cycles.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        op_valid   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = VALID;
            end
            VALID: begin
                op_valid  = 1'b1;
                req_ready = op_ready;
                if (op_ready) begin
                    state_next = req_valid ? FETCH : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A writeback in the issue cycle hits the register file in the same
    // edge as the read, so the file returns the old value; remember the
    // new one here. r0 is never forwarded.
    assign issue_hit_a = wb_valid && (req_rs1 != 4'd0) && (wb_addr == req_rs1);
    assign issue_hit_b = wb_valid && (req_rs2 != 4'd0) && (wb_addr == req_rs2);

    // Latch the source addresses and issue-cycle forwards; both flags are
    // rewritten on every issue, which clears any stale forward.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs1_q        <= 4'd0;
            rs2_q        <= 4'd0;
            fwd_a_q      <= 1'b0;
            fwd_b_q      <= 1'b0;
            fwd_data_a_q <= 32'd0;
            fwd_data_b_q <= 32'd0;
        end else if (issue) begin
            rs1_q        <= req_rs1;
            rs2_q        <= req_rs2;
            fwd_a_q      <= issue_hit_a;
            fwd_b_q      <= issue_hit_b;
            fwd_data_a_q <= wb_data;
            fwd_data_b_q <= wb_data;
        end
    end

    // Operand selection during FETCH. A writeback in the fetch cycle is the
    // newest value and beats the issue-cycle forward; r0 always reads 0.
    assign fetch_hit_a = wb_valid && (wb_addr == rs1_q);
    assign fetch_hit_b = wb_valid && (wb_addr == rs2_q);

    always_comb begin
        sel_a = rf_read_data_a;
        if (rs1_q == 4'd0) begin
            sel_a = 32'd0;
        end else if (fetch_hit_a) begin
            sel_a = wb_data;
        end else if (fwd_a_q) begin
            sel_a = fwd_data_a_q;
        end
    end

    always_comb begin
        sel_b = rf_read_data_b;
        if (rs2_q == 4'd0) begin
            sel_b = 32'd0;
        end else if (fetch_hit_b) begin
            sel_b = wb_data;
        end else if (fwd_b_q) begin
            sel_b = fwd_data_b_q;
        end
    end

    // Operand registers load only at the end of FETCH, so writebacks seen
    // while the operands are held in VALID cannot disturb them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a <= 32'd0;
            op_b <= 32'd0;
        end else if (state == FETCH) begin
            op_a <= sel_a;
            op_b <= sel_b;
        end
    end

    // Register-file ports. Read addresses are parked at 0 outside issue
    // cycles; writes to r0 are suppressed at the enable.
    assign rf_read_addr_a = issue ? req_rs1 : 4'd0;
    assign rf_read_addr_b = issue ? req_rs2 : 4'd0;
    assign rf_available   = issue | wb_valid;
    assign rf_write_en    = wb_valid & (wb_addr != 4'd0);
    assign rf_write_addr  = wb_addr;
    assign rf_write_data  = wb_data;

endmodule

// File: tb/tb_register_access_controller.sv
// ---------------------------------------------------------------------------
// tb_register_access_controller
//
// Bench for register_access_controller. Contains a simple 16x32 register
// file (registered read, write on enable, cleared by reset) connected to the
// DUT. A behavioural model tracks the architectural register values and
// whether a fetch is in flight or operands are held. Operands are the
// register contents after the writebacks of the fetch cycle.
// ---------------------------------------------------------------------------
module tb_register_access_controller;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_rs1;
    logic [3:0]  req_rs2;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rf_available;
    logic        rf_write_en;
    logic [3:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [3:0]  rf_read_addr_a;
    logic [31:0] rf_read_data_a;
    logic [3:0]  rf_read_addr_b;
    logic [31:0] rf_read_data_b;

    int tests_run;
    int tests_failed;

    // Behavioural model state.
    logic [31:0] arch [16];
    logic        m_fetching;
    logic        m_holding;
    logic [3:0]  m_rs1;
    logic [3:0]  m_rs2;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic        m_issue;

    // Register file attached to the DUT.
    logic [31:0] rf_mem [16];

    register_access_controller dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rs1        (req_rs1),
        .req_rs2        (req_rs2),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_a           (op_a),
        .op_b           (op_b),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .rf_available   (rf_available),
        .rf_write_en    (rf_write_en),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .rf_read_addr_a (rf_read_addr_a),
        .rf_read_data_a (rf_read_data_a),
        .rf_read_addr_b (rf_read_addr_b),
        .rf_read_data_b (rf_read_data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: reads return the pre-write contents of the same edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 32'd0;
            rf_read_data_a <= 32'd0;
            rf_read_data_b <= 32'd0;
        end else begin
            rf_read_data_a <= rf_mem[rf_read_addr_a];
            rf_read_data_b <= rf_mem[rf_read_addr_b];
            if (rf_write_en && rf_write_addr != 4'd0) begin
                rf_mem[rf_write_addr] <= rf_write_data;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) arch[i] = 32'd0;
        m_fetching = 1'b0;
        m_holding  = 1'b0;
        m_rs1      = 4'd0;
        m_rs2      = 4'd0;
        m_a        = 32'd0;
        m_b        = 32'd0;
        m_issue    = 1'b0;
    endtask

    // Compare every DUT output against the model for the current inputs.
    task automatic checkOutput();
        logic exp_ready;
        exp_ready = !m_fetching && (!m_holding || op_ready);
        m_issue   = req_valid && exp_ready;
        check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        check("op_valid", {31'd0, op_valid}, {31'd0, m_holding});
        if (m_holding) begin
            check("op_a", op_a, m_a);
            check("op_b", op_b, m_b);
        end
        check("rf_available", {31'd0, rf_available}, {31'd0, m_issue || wb_valid});
        check("rf_write_en", {31'd0, rf_write_en}, {31'd0, wb_valid && wb_addr != 4'd0});
        check("rf_write_addr", {28'd0, rf_write_addr}, {28'd0, wb_addr});
        check("rf_write_data", rf_write_data, wb_data);
        check("rf_read_addr_a", {28'd0, rf_read_addr_a}, {28'd0, m_issue ? req_rs1 : 4'd0});
        check("rf_read_addr_b", {28'd0, rf_read_addr_b}, {28'd0, m_issue ? req_rs2 : 4'd0});
    endtask

    // Advance the model across a clock edge using this cycle's inputs.
    task automatic updateModel();
        if (wb_valid && wb_addr != 4'd0) arch[wb_addr] = wb_data;
        if (m_fetching) begin
            m_a        = arch[m_rs1];
            m_b        = arch[m_rs2];
            m_fetching = 1'b0;
            m_holding  = 1'b1;
        end else if (m_holding && op_ready) begin
            m_holding = 1'b0;
        end
        if (m_issue) begin
            m_fetching = 1'b1;
            m_rs1      = req_rs1;
            m_rs2      = req_rs2;
        end
    endtask

    // One full cycle: drive at the falling edge, check, then step the model.
    task automatic applyStimulus(input logic rv, input logic [3:0] r1, input logic [3:0] r2,
                                 input logic ordy, input logic wv, input logic [3:0] wa,
                                 input logic [31:0] wd);
        @(negedge clk);
        req_valid = rv;
        req_rs1   = r1;
        req_rs2   = r2;
        op_ready  = ordy;
        wb_valid  = wv;
        wb_addr   = wa;
        wb_data   = wd;
        #1;
        checkOutput();
        @(posedge clk);
        updateModel();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        modelReset();

        // Reset state, with traffic present on the inputs.
        reset_n   = 1'b0;
        req_valid = 1'b1;
        req_rs1   = 4'd6;
        req_rs2   = 4'd9;
        op_ready  = 1'b0;
        wb_valid  = 1'b1;
        wb_addr   = 4'd2;
        wb_data   = 32'h1234_5678;
        #3;
        check("reset op_valid", {31'd0, op_valid}, 32'd0);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset op_a", op_a, 32'd0);
        check("reset op_b", op_b, 32'd0);
        check("reset rf_available", {31'd0, rf_available}, 32'd1);
        check("reset rf_read_addr_a", {28'd0, rf_read_addr_a}, 32'd0);
        check("reset rf_write_en", {31'd0, rf_write_en}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wb_valid  = 1'b0;
        reset_n   = 1'b1;

        // Basic fetch.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 32'h1111_1111);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 32'h2222_2222);
        applyStimulus(1'b1, 4'd3, 4'd5, 1'b0, 1'b0, 4'd0, 32'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        #1;
        check("basic op_valid", {31'd0, op_valid}, 32'd1);
        check("basic op_a", op_a, 32'h1111_1111);
        check("basic op_b", op_b, 32'h2222_2222);
        idleCycle();

        // Zero register.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        #1;
        check("zero op_a", op_a, 32'd0);
        check("zero op_b", op_b, 32'd0);
        idleCycle();

        // Issue-cycle forward.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 32'h0000_0001);
        applyStimulus(1'b1, 4'd4, 4'd5, 1'b0, 1'b1, 4'd4, 32'hABCD_0001);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        #1;
        check("issue fwd op_a", op_a, 32'hABCD_0001);
        idleCycle();

        // Fetch-cycle forward priority, then backpressure and back-to-back.
        applyStimulus(1'b1, 4'd3, 4'd7, 1'b0, 1'b1, 4'd7, 32'h0000_0001);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 32'h0000_0002);
        #1;
        check("fetch fwd op_b", op_b, 32'h0000_0002);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 32'h0000_0003);
        applyStimulus(1'b1, 4'd7, 4'd4, 1'b0, 1'b0, 4'd0, 32'd0);
        applyStimulus(1'b1, 4'd7, 4'd4, 1'b0, 1'b0, 4'd0, 32'd0);
        #1;
        check("held op_b", op_b, 32'h0000_0002);
        check("held op_a", op_a, 32'h1111_1111);
        check("held op_valid", {31'd0, op_valid}, 32'd1);
        applyStimulus(1'b1, 4'd7, 4'd4, 1'b1, 1'b0, 4'd0, 32'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        #1;
        check("b2b op_a", op_a, 32'h0000_0003);
        check("b2b op_b", op_b, 32'hABCD_0001);
        idleCycle();

        // Asynchronous reset in the middle of a fetch.
        applyStimulus(1'b1, 4'd3, 4'd5, 1'b0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        op_ready  = 1'b0;
        wb_valid  = 1'b1;
        wb_addr   = 4'd9;
        wb_data   = 32'h9999_9999;
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset op_valid", {31'd0, op_valid}, 32'd0);
        check("midreset req_ready", {31'd0, req_ready}, 32'd1);
        check("midreset op_a", op_a, 32'd0);
        check("midreset op_b", op_b, 32'd0);
        check("midreset rf_write_en", {31'd0, rf_write_en}, 32'd1);
        modelReset();
        @(negedge clk);
        wb_valid = 1'b0;
        reset_n  = 1'b1;
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 32'h0000_0055);
        applyStimulus(1'b1, 4'd5, 4'd3, 1'b0, 1'b0, 4'd0, 32'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        #1;
        check("post reset op_a", op_a, 32'h0000_0055);
        check("post reset op_b", op_b, 32'd0);
        idleCycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 9) < 7,
                          4'($urandom_range(0, 7)),
                          4'($urandom_range(0, 7)),
                          $urandom_range(0, 9) < 6,
                          $urandom_range(0, 1) == 1,
                          4'($urandom_range(0, 7)),
                          $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_access_controller.md
# register_access_controller

Initiator-side sequencer for the 16x32 register file. It accepts operand-fetch requests (rs1/rs2) over a valid/ready handshake and drives the register file's read ports and `available` strobe. It forwards same-window writebacks so operands are never stale, and returns both operands on a registered valid/ready output. Writeback requests always pass straight through to the register file write port. The block sits between instruction decode/writeback and the register file in the core.

## Interface
Parameters: none. Widths are fixed: 4-bit register address, 32-bit data.

- `clk`  in  1  core clock; all state updates on posedge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  fetch request present
- `req_ready`  out  1  request accepted this cycle when high with `req_valid`
- `req_rs1`  in  4  source register A address
- `req_rs2`  in  4  source register B address
- `op_valid`  out  1  operands valid
- `op_ready`  in  1  consumer takes operands this cycle
- `op_a`  out  32  operand A (registered)
- `op_b`  out  32  operand B (registered)
- `wb_valid`  in  1  writeback this cycle; always accepted, no ready
- `wb_addr`  in  4  writeback destination
- `wb_data`  in  32  writeback data
- `rf_available`  out  1  register-file operation strobe
- `rf_write_en`  out  1  register-file write enable
- `rf_write_addr`  out  4  register-file write address
- `rf_write_data`  out  32  register-file write data
- `rf_read_addr_a`  out  4  register-file read address A
- `rf_read_data_a`  in  32  register-file read data A; registered, valid the cycle after issue
- `rf_read_addr_b`  out  4  register-file read address B
- `rf_read_data_b`  in  32  register-file read data B; registered, valid the cycle after issue

## Operation
- States:
  - IDLE: `req_ready`=1.
  - FETCH: `req_ready`=0; read data arrives.
  - VALID: `op_valid`=1; `req_ready`=`op_ready`.
- Issue cycle: the cycle in which `req_valid & req_ready`.
  - Drive `rf_read_addr_a/b` = `req_rs1/rs2`.
  - Latch rs1/rs2 internally.
  - Go to FETCH.
- Non-issue cycles: `rf_read_addr_a/b` = 0.
- `rf_available` = issue | `wb_valid`.
- `rf_write_en` = `wb_valid & (wb_addr != 0)`.
- `rf_write_addr`/`rf_write_data` = `wb_addr`/`wb_data` (combinational).
- Operand semantics: each operand equals the register value after all writebacks up to and including the FETCH cycle. Writebacks after FETCH do not alter held operands.
- Forwarding, per port, for latched rs != 0:
  - In the issue cycle, if `wb_valid` and `wb_addr` == rs: set forward flag and capture `wb_data`. The register file returns the pre-write value here.
  - In the FETCH cycle, if `wb_valid` and `wb_addr` == rs: use `wb_data`. This takes priority over the issue-cycle forward.
  - Otherwise use the issue-cycle forward if its flag is set, else `rf_read_data`.
- rs == 0: operand is 0; forwarding is never applied.
- FETCH -> VALID: the selected values load `op_a`/`op_b` at the end of FETCH.
- VALID transitions:
  - `op_ready` & `req_valid`: issue the new request in the same cycle, go to FETCH.
  - `op_ready` & !`req_valid`: go to IDLE.
  - !`op_ready`: hold; `op_a`/`op_b` stay stable.
- Forward flags clear on each issue.

## Timing
- Reset values (asynchronous): state = IDLE; `req_ready`=1; `op_valid`=0; `op_a`=`op_b`=0; forward flags 0.
  - Combinational outputs during reset: `rf_available`, `rf_write_en`, read addresses follow their equations, with issue = 0.
- Latency: issue in cycle N -> `op_valid`=1 in cycle N+2.
- Throughput: one request per 2 cycles with `op_ready` held high.
- `op_valid` deasserts only after a handshake cycle (`op_valid & op_ready`).
- `wb_valid` is honoured in every state, including reset-released IDLE. There is no backpressure on writeback.
- Reset asserted mid-FETCH or mid-VALID:
  - The operation is dropped; `op_valid` drops immediately.
  - A writeback presented in that cycle still reaches the register file combinationally. The register file's own reset takes precedence.

## Test plan
- Basic fetch:
  - Preload r3=0x11111111 and r5=0x22222222 via wb.
  - Request rs1=3, rs2=5 in cycle N -> `op_valid` in N+2 with `op_a`=0x11111111, `op_b`=0x22222222.
  - `rf_available`=1 only in writeback and issue cycles.
- Zero register:
  - wb r0=0xDEADBEEF, then request rs1=0, rs2=0 -> `op_a`=`op_b`=0; `rf_write_en`=0 during that wb.
- Issue-cycle forward:
  - r4=1; in the issue cycle for rs1=4, wb r4=0xABCD0001 -> `op_a`=0xABCD0001.
- FETCH-cycle forward priority:
  - Issue rs2=7 with wb r7=0x1 in the same cycle, then wb r7=0x2 in FETCH -> `op_b`=0x2.
  - A wb r7=0x3 during VALID leaves `op_b`=0x2.
- Backpressure and back-to-back:
  - Hold `op_ready`=0 for 3 cycles -> `op_a`/`op_b` stable, `req_ready`=0.
  - Raise `op_ready` with `req_valid`=1 -> new issue that cycle; next `op_valid` 2 cycles later.
- Async reset:
  - Assert `reset_n`=0 mid-FETCH, between edges -> `op_valid`=0, `op_a`=`op_b`=0, `req_ready`=1 immediately.
  - After release, a new request completes normally.
